// File: rtl/i8080_pkg.sv
// i8080_pkg: shared cycle-type, status-byte and bus-state definitions
package i8080_pkg;
  typedef enum logic [2:0] {FETCH, MEM_RD, MEM_WR, STK_RD, STK_WR, IO_IN, IO_OUT, INTA} cyc_type_t;
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} bus_state_t;
  localparam logic [7:0] ST_FETCH  = 8'hA2;
  localparam logic [7:0] ST_MEM_RD = 8'h82;
  localparam logic [7:0] ST_MEM_WR = 8'h00;
  localparam logic [7:0] ST_STK_RD = 8'h86;
  localparam logic [7:0] ST_STK_WR = 8'h04;
  localparam logic [7:0] ST_IO_IN  = 8'h42;
  localparam logic [7:0] ST_IO_OUT = 8'h10;
  localparam logic [7:0] ST_INTA   = 8'h23;
  function automatic logic [7:0] status_of(cyc_type_t t);
    case (t)
      FETCH:   return ST_FETCH;
      MEM_RD:  return ST_MEM_RD;
      MEM_WR:  return ST_MEM_WR;
      STK_RD:  return ST_STK_RD;
      STK_WR:  return ST_STK_WR;
      IO_IN:   return ST_IO_IN;
      IO_OUT:  return ST_IO_OUT;
      default: return ST_INTA;
    endcase
  endfunction
  function automatic logic is_read(cyc_type_t t);
    return !(t == MEM_WR || t == STK_WR || t == IO_OUT);
  endfunction
endpackage

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 8080-style machine-cycle sequencer (T1/T2/TW/T3) with wait-state timeout
module bus_cycle_ctrl
  import i8080_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk50M_i,
  input  logic        rst_i,
  input  logic        cyc_req_i,
  input  logic [2:0]  cyc_type_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  input  logic        ready_i,
  input  logic [7:0]  ext_rdata_i,
  output logic [15:0] addr_o,
  output logic [7:0]  status_o,
  output logic        sync_o,
  output logic        dbin_o,
  output logic        wr_no,
  output logic [7:0]  wdata_o,
  output logic        wdata_oe_o,
  output logic [7:0]  rdata_o,
  output logic        cyc_ack_o,
  output logic        cyc_done_o,
  output logic        busy_o,
  output logic        wait_o,
  output logic        timeout_o
);
  bus_state_t state, nxt;
  cyc_type_t  typ;
  logic [7:0] wcnt;
  logic       start, tmo, rd, phase;
  // next-state decision; a new cycle may start only from IDLE or T3
  always_comb begin
    start = cyc_req_i && (state == S_IDLE || state == S_T3);
    tmo   = state == S_TW && !ready_i && wcnt == 8'(WAIT_MAX);
    rd    = is_read(typ);
    nxt   = start ? S_T1 :
            state == S_T1 ? S_T2 :
            state == S_T2 ? (ready_i ? S_T3 : S_TW) :
            state == S_TW ? (ready_i ? S_T3 : (tmo ? S_IDLE : S_TW)) : S_IDLE;
    phase = nxt == S_T2 || nxt == S_TW || nxt == S_T3;
  end
  // state, latched cycle attributes and registered bus strobes derived from the next state
  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      typ        <= FETCH;
      wcnt       <= '0;
      addr_o     <= '0;
      status_o   <= '0;
      wdata_o    <= '0;
      rdata_o    <= '0;
      sync_o     <= 1'b0;
      cyc_ack_o  <= 1'b0;
      dbin_o     <= 1'b0;
      wdata_oe_o <= 1'b0;
      wr_no      <= 1'b1;
      cyc_done_o <= 1'b0;
      busy_o     <= 1'b0;
      wait_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        typ      <= cyc_type_t'(cyc_type_i);
        addr_o   <= addr_i;
        status_o <= status_of(cyc_type_t'(cyc_type_i));
        wdata_o  <= wdata_i;
      end
      if (state == S_T3 && rd) rdata_o <= ext_rdata_i;
      wcnt       <= start ? 8'd0 : (nxt == S_TW ? wcnt + 8'd1 : wcnt);
      sync_o     <= nxt == S_T1;
      cyc_ack_o  <= nxt == S_T1;
      dbin_o     <= phase && rd;
      wdata_oe_o <= phase && !rd;
      wr_no      <= !(nxt == S_T3 && !rd);
      cyc_done_o <= state == S_T3;
      busy_o     <= nxt != S_IDLE;
      wait_o     <= nxt == S_TW;
      timeout_o  <= tmo;
    end
  end
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed and randomized checks of bus_cycle_ctrl against a transaction-level model
module tb_bus_cycle_ctrl;
  localparam int WM = 4;
  logic        clk = 1'b0;
  logic        rst_i, cyc_req_i, ready_i;
  logic [2:0]  cyc_type_i;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i, ext_rdata_i;
  logic [15:0] addr_o;
  logic [7:0]  status_o, wdata_o, rdata_o;
  logic        sync_o, dbin_o, wr_no, wdata_oe_o, cyc_ack_o, cyc_done_o, busy_o, wait_o, timeout_o;
  int          n_chk = 0, n_fail = 0;
  logic        exp_done = 1'b0;
  logic [7:0]  exp_rdata = 8'h00;
  logic [7:0]  st_tab [8] = '{8'hA2, 8'h82, 8'h00, 8'h86, 8'h04, 8'h42, 8'h10, 8'h23};
  logic [7:0]  rd_mask = 8'hAB;
  bit          ended;

  bus_cycle_ctrl #(.WAIT_MAX(WM)) dut (
    .clk50M_i(clk), .rst_i(rst_i), .cyc_req_i(cyc_req_i), .cyc_type_i(cyc_type_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_i(ready_i), .ext_rdata_i(ext_rdata_i),
    .addr_o(addr_o), .status_o(status_o), .sync_o(sync_o), .dbin_o(dbin_o), .wr_no(wr_no),
    .wdata_o(wdata_o), .wdata_oe_o(wdata_oe_o), .rdata_o(rdata_o), .cyc_ack_o(cyc_ack_o),
    .cyc_done_o(cyc_done_o), .busy_o(busy_o), .wait_o(wait_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] st, input logic [15:0] a, input logic [7:0] wd,
                           input bit ack, input bit dbin, input bit oe, input bit wrn, input bit wt);
    check({tag, "_ack"}, cyc_ack_o, ack);
    check({tag, "_sync"}, sync_o, ack);
    check({tag, "_status"}, status_o, st);
    check({tag, "_addr"}, addr_o, a);
    check({tag, "_wdata"}, wdata_o, wd);
    check({tag, "_dbin"}, dbin_o, dbin);
    check({tag, "_oe"}, wdata_oe_o, oe);
    check({tag, "_wrn"}, wr_no, wrn);
    check({tag, "_wait"}, wait_o, wt);
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_done"}, cyc_done_o, exp_done);
    check({tag, "_tmo"}, timeout_o, 0);
    check({tag, "_rdata"}, rdata_o, exp_rdata);
    exp_done = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input bit tmo);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_ack"}, cyc_ack_o, 0);
    check({tag, "_sync"}, sync_o, 0);
    check({tag, "_dbin"}, dbin_o, 0);
    check({tag, "_oe"}, wdata_oe_o, 0);
    check({tag, "_wrn"}, wr_no, 1);
    check({tag, "_wait"}, wait_o, 0);
    check({tag, "_done"}, cyc_done_o, exp_done);
    check({tag, "_tmo"}, timeout_o, tmo);
    check({tag, "_rdata"}, rdata_o, exp_rdata);
    exp_done = 1'b0;
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    chk_idle("idle", 0);
  endtask

  // one machine cycle: nw consecutive low READY samples from T2 on; more than WM of them aborts
  task automatic do_cycle(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] rdv, input int nw, output bit ok_t3);
    bit rd = rd_mask[t];
    logic [7:0] st = st_tab[t];
    int ntw = nw > WM ? WM : nw;
    cyc_req_i = 1'b1; cyc_type_i = t; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    chk_state("t1", st, a, wd, 1, 0, 0, 1, 0);
    cyc_req_i = 1'b0;
    @(posedge clk); #1;
    chk_state("t2", st, a, wd, 0, rd, !rd, 1, 0);
    ext_rdata_i = rdv;
    ready_i = nw > 0 ? 1'b0 : 1'b1;
    for (int j = 1; j <= ntw; j++) begin
      @(posedge clk); #1;
      chk_state("tw", st, a, wd, 0, rd, !rd, 1, 1);
      ready_i = j < nw ? 1'b0 : 1'b1;
    end
    @(posedge clk); #1;
    if (nw > WM) begin
      chk_idle("timeout", 1);
      ok_t3 = 1'b0;
    end else begin
      chk_state("t3", st, a, wd, 0, rd, !rd, rd, 0);
      exp_done = 1'b1;
      if (rd) exp_rdata = rdv;
      ok_t3 = 1'b1;
    end
    ready_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1; cyc_req_i = 1'b0; ready_i = 1'b1; cyc_type_i = '0;
    addr_i = '0; wdata_i = '0; ext_rdata_i = '0;
    repeat (2) @(posedge clk); #1;
    chk_idle("reset", 0);
    check("reset_addr", addr_o, 0);
    check("reset_status", status_o, 0);
    check("reset_wdata", wdata_o, 0);
    rst_i = 1'b0;
    do_cycle(3'd1, 16'h1234, 8'h00, 8'h5A, 0, ended);
    idle_step();
    do_cycle(3'd2, 16'h2000, 8'hC3, 8'h00, 3, ended);
    idle_step();
    do_cycle(3'd1, 16'h4321, 8'h00, 8'hEE, 9, ended);
    idle_step();
    do_cycle(3'd1, 16'h0F0F, 8'h00, 8'h99, WM, ended);
    idle_step();
    do_cycle(3'd0, 16'h0100, 8'h00, 8'h3E, 0, ended);
    do_cycle(3'd4, 16'hFFFE, 8'h77, 8'h00, 0, ended);
    idle_step();
    cyc_req_i = 1'b1; cyc_type_i = 3'd5; addr_i = 16'h0042; wdata_i = 8'h11;
    @(posedge clk); #1;
    chk_state("io_t1", 8'h42, 16'h0042, 8'h11, 1, 0, 0, 1, 0);
    cyc_req_i = 1'b0;
    @(posedge clk); #1;
    ready_i = 1'b0;
    @(posedge clk); #1;
    check("io_tw_wait", wait_o, 1);
    #3 rst_i = 1'b1;
    #1;
    exp_rdata = 8'h00;
    chk_idle("async_rst", 0);
    check("async_rst_addr", addr_o, 0);
    check("async_rst_status", status_o, 0);
    check("async_rst_wdata", wdata_o, 0);
    @(posedge clk); #1;
    chk_idle("rst_hold", 0);
    rst_i = 1'b0; ready_i = 1'b1;
    idle_step();
    do_cycle(3'd5, 16'h0042, 8'h00, 8'hA5, 1, ended);
    idle_step();
    for (int i = 0; i < 60; i++) begin
      do_cycle(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, WM + 2)), ended);
      if ($urandom_range(0, 2) == 0) idle_step();
    end
    idle_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 255, giving the maximum number of consecutive TW cycles before the cycle is aborted (range 1..255).
REQ-002 The block SHALL have port clk50M_i, input, 1 bit: the single system clock; all flops update on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous reset, active-high.
REQ-004 The block SHALL have port cyc_req_i, input, 1 bit: a machine-cycle request from the control unit.
REQ-005 The block SHALL have port cyc_type_i, input, 3 bits: the cycle type (FETCH, MEM_RD, MEM_WR, STK_RD, STK_WR, IO_IN, IO_OUT, INTA).
REQ-006 The block SHALL have port addr_i, input, 16 bits: the address from the address latch.
REQ-007 The block SHALL have port wdata_i, input, 8 bits: write data from the internal data bus.
REQ-008 The block SHALL have port ready_i, input, 1 bit: external READY; low requests wait states.
REQ-009 The block SHALL have port ext_rdata_i, input, 8 bits: the external data-bus input.
REQ-010 The block SHALL have ports addr_o (output, 16 bits: external address), status_o (output, 8 bits: 8080 status byte) and sync_o (output, 1 bit: SYNC).
REQ-011 The block SHALL have ports dbin_o (output, 1 bit: read strobe), wr_no (output, 1 bit: active-low write strobe), wdata_o (output, 8 bits) and wdata_oe_o (output, 1 bit: external data-bus drive enable).
REQ-012 The block SHALL have ports rdata_o (output, 8 bits: captured read data), cyc_ack_o (output, 1 bit), cyc_done_o (output, 1 bit), busy_o (output, 1 bit), wait_o (output, 1 bit) and timeout_o (output, 1 bit).

Function
REQ-013 The block SHALL implement the FSM states IDLE, T1, T2, TW and T3.
REQ-014 From IDLE or T3 with cyc_req_i=1, the block SHALL move to T1 and latch cyc_type_i, addr_i and wdata_i.
REQ-015 cyc_req_i in T1, T2 or TW SHALL be ignored; the requester holds it until cyc_ack_o is seen.
REQ-016 In T1, cyc_ack_o=1 and sync_o=1 for exactly one cycle, and status_o SHALL equal the type code: FETCH A2h, MEM_RD 82h, MEM_WR 00h, STK_RD 86h, STK_WR 04h, IO_IN 42h, IO_OUT 10h, INTA 23h.
REQ-017 addr_o and status_o SHALL hold their latched values from T1 through T3.
REQ-018 T1 SHALL always go to T2.
REQ-019 In T2 with ready_i=1, the next state SHALL be T3; with ready_i=0, the next state SHALL be TW.
REQ-020 In TW, the block SHALL stay in TW while ready_i=0 and move to T3 on ready_i=1; wait_o=1 in every TW cycle.
REQ-021 The wait counter SHALL be 8 bits, SHALL clear on T1 and SHALL increment each TW cycle.
REQ-022 When the wait counter reaches WAIT_MAX with ready_i still 0, the block SHALL go to IDLE, pulse timeout_o for 1 cycle, and SHALL NOT assert cyc_done_o or update rdata_o.
REQ-023 For read types (FETCH, MEM_RD, STK_RD, IO_IN, INTA), dbin_o=1 in T2, TW and T3, and rdata_o SHALL capture ext_rdata_i on the edge leaving T3.
REQ-024 For write types (MEM_WR, STK_WR, IO_OUT), wdata_oe_o=1 in T2, TW and T3, and wr_no=0 in T3 only.
REQ-025 cyc_done_o SHALL be a 1-cycle pulse in the cycle after T3.
REQ-026 Latency from request to done SHALL be 4 cycles with zero wait states (request sampled at c0, T1 c1, T2 c2, T3 c3, done c4), plus 1 cycle per TW.
REQ-027 A request accepted in T3 SHALL produce T1 at c4, concurrent with cyc_done_o of the prior cycle (back-to-back with no idle cycle).
REQ-028 busy_o SHALL be 1 in T1, T2, TW and T3.
REQ-029 Undefined combinations SHALL NOT occur: dbin_o and wdata_oe_o are never both 1, and wr_no=0 never coincides with dbin_o=1.

Reset
REQ-030 On rst_i=1, the block SHALL go to IDLE immediately, regardless of cycle phase.
REQ-031 Reset values SHALL be: addr_o 0000h, status_o 00h, sync_o 0, dbin_o 0, wr_no 1, wdata_o 00h, wdata_oe_o 0, rdata_o 00h, cyc_ack_o 0, cyc_done_o 0, busy_o 0, wait_o 0, timeout_o 0, wait counter 0.
REQ-032 Reset mid-cycle SHALL drop any strobe the same cycle and SHALL NOT produce cyc_done_o or timeout_o.

Structure
REQ-033 The cycle-type enum, the status-byte constants and the FSM state enum SHALL reside in the shared package i8080_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the status encode SHALL be a package function.

Verification
REQ-035 MEM_RD to addr 1234h with ready_i=1 and ext_rdata_i=5Ah SHALL give: sync_o and status_o=82h at c1, dbin_o at c2..c3, rdata_o=5Ah and cyc_done_o at c4.
REQ-036 MEM_WR to addr 2000h with wdata_i=C3h and ready_i low for 3 cycles SHALL give: wait_o for 3 cycles, wr_no=0 for one cycle with wdata_o=C3h, cyc_done_o at c7.
REQ-037 With ready_i held at 0 and WAIT_MAX=4, the block SHALL produce 4 TW cycles, then timeout_o=1 for one cycle, return to IDLE, with no cyc_done_o and rdata_o unchanged.
REQ-038 FETCH immediately followed by STK_WR (request held through T3) SHALL produce T1 status 04h in the same cycle as the FETCH cyc_done_o, with no idle cycle.
REQ-039 Asserting rst_i during TW of an IO_IN cycle SHALL return all outputs to reset values asynchronously, with no done pulse; a new request after reset SHALL complete normally.
